// File: rtl/epu_dma_wr_master.sv
// rtl/epu_dma_wr_master.sv - DMA write master: stages a 32-bit word stream in a FIFO and writes it out as AXI INCR bursts
module epu_dma_wr_master #(
    parameter int         FIFO_DEPTH = 8,
    parameter int         MAX_BURST  = 16,
    parameter logic [3:0] MST_ID     = 4'h1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_cnt,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    localparam int          PW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] MAX_BURST_W = 16'(MAX_BURST);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0] r_addr;
    logic [15:0] r_remaining;
    logic [15:0] r_word_cnt;
    logic [15:0] r_acc_cnt;
    logic [3:0]  r_beat_cnt;
    logic [31:0] r_awaddr;
    logic [3:0]  r_awlen;
    logic        r_err;

    logic [31:0] r_mem [FIFO_DEPTH];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;

    logic        w_empty;
    logic        w_full;
    logic        w_busy;
    logic        w_wvalid;
    logic        w_wlast;
    logic        w_pop;
    logic        w_push;
    logic        w_s_ready;
    logic        w_b_bad;
    logic        w_load_aw;
    logic [15:0] w_burst_src;
    logic [4:0]  w_beats;
    logic [4:0]  w_len_next;
    logic [4:0]  w_burst_beats;
    logic [31:0] w_awaddr_next;
    logic        w_unused;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_busy   = (r_state != ST_IDLE);
    assign w_wvalid = (r_state == ST_W) && !w_empty;
    assign w_wlast  = w_wvalid && (r_beat_cnt == r_awlen);
    assign w_pop    = w_wvalid && WREADY;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a word.
    assign w_s_ready = w_busy && (!w_full || w_pop) && (r_acc_cnt < r_word_cnt);
    assign w_push    = s_valid && w_s_ready;
    assign w_b_bad   = (BRESP != 2'b00) || (BID != MST_ID);

    // First burst is sized from the start inputs, later ones from the running counters.
    assign w_burst_src   = (r_state == ST_IDLE) ? word_cnt : r_remaining;
    assign w_beats       = (w_burst_src > MAX_BURST_W) ? MAX_BURST_W[4:0] : w_burst_src[4:0];
    assign w_len_next    = w_beats - 5'd1;
    assign w_burst_beats = {1'b0, r_awlen} + 5'd1;
    assign w_awaddr_next = (r_state == ST_IDLE) ? {base_addr[31:2], 2'b00} : r_addr;
    assign w_load_aw     = (r_state != ST_AW) && (w_next == ST_AW);
    assign w_unused      = ^{base_addr[1:0], w_burst_src[15:5], w_len_next[4]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (word_cnt != 16'd0) ? ST_AW : ST_FIN;
                end
            end
            ST_AW: begin
                if (AWREADY) begin
                    w_next = ST_W;
                end
            end
            ST_W: begin
                if (w_pop && w_wlast) begin
                    w_next = ST_B;
                end
            end
            ST_B: begin
                if (BVALID) begin
                    w_next = (w_b_bad || (r_remaining == 16'd0)) ? ST_FIN : ST_AW;
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_addr      <= 32'd0;
            r_remaining <= 16'd0;
            r_word_cnt  <= 16'd0;
            r_acc_cnt   <= 16'd0;
            r_beat_cnt  <= 4'd0;
            r_awaddr    <= 32'd0;
            r_awlen     <= 4'd0;
            r_err       <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_addr      <= {base_addr[31:2], 2'b00};
                r_remaining <= word_cnt;
                r_word_cnt  <= word_cnt;
                r_acc_cnt   <= 16'd0;
                r_err       <= 1'b0;
            end
            if (w_load_aw) begin
                r_awaddr   <= w_awaddr_next;
                r_awlen    <= w_len_next[3:0];
                r_beat_cnt <= 4'd0;
            end
            if (w_push) begin
                r_acc_cnt <= r_acc_cnt + 16'd1;
            end
            if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
                if (w_wlast) begin
                    r_addr      <= r_addr + {25'd0, w_burst_beats, 2'b00};
                    r_remaining <= r_remaining - {11'd0, w_burst_beats};
                end
            end
            if ((r_state == ST_B) && BVALID && w_b_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // FIN always empties the FIFO, dropping words left behind by an aborted transfer.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (r_state == ST_FIN) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr[PW-1:0]] <= s_data;
        end
    end

    assign s_ready = w_s_ready;
    assign busy    = w_busy;
    assign done    = (r_state == ST_FIN);
    assign err     = r_err;

    assign AWID    = MST_ID;
    assign AWADDR  = r_awaddr;
    assign AWLEN   = r_awlen;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWVALID = (r_state == ST_AW);

    assign WDATA  = w_wvalid ? r_mem[r_rptr[PW-1:0]] : 32'd0;
    assign WSTRB  = 4'hF;
    assign WLAST  = w_wlast;
    assign WVALID = w_wvalid;

    assign BREADY = (r_state == ST_B);

endmodule

// File: tb/tb_epu_dma_wr_master.sv
// tb/tb_epu_dma_wr_master.sv - scoreboard bench for epu_dma_wr_master
module tb_epu_dma_wr_master;

    localparam logic [3:0] ID = 4'h1;

    logic        CLK, RSTn, start;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic [31:0] s_data;
    logic        s_valid, s_ready, busy, done, err;
    logic [3:0]  AWID, AWLEN;
    logic [31:0] AWADDR, WDATA;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST, BRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]  WSTRB, BID;

    epu_dma_wr_master #(.FIFO_DEPTH(8), .MAX_BURST(16), .MST_ID(ID)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .busy(busy), .done(done), .err(err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [35:0] exp_aw_q[$];
    logic [32:0] exp_w_q[$];
    logic [31:0] src_q[$];
    logic [1:0]  resp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0, b_cnt = 0, aw_cnt = 0, w_hs_cnt = 0, outstanding = 0;
    int b_cyc = 0, done_cyc = 0;
    bit f_s_hs = 0, f_w_last_hs = 0, f_b_hs = 0;
    bit held = 0, bpend = 0, gaps = 0, wtoggle = 0;
    logic [31:0] held_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: handshake with empty scoreboard", name);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
    always @(negedge CLK) begin
        logic [35:0] ea;
        logic [32:0] ew;
        cyc++;
        f_s_hs = 0;
        f_w_last_hs = 0;
        f_b_hs = 0;
        if (RSTn) begin
            if (held) begin
                check("w_stable_valid", 64'(WVALID), 64'd1);
                check("w_stable_data", 64'(WDATA), 64'(held_data));
            end
            held = WVALID && !WREADY;
            held_data = WDATA;
            if (AWVALID && AWREADY) begin
                check("aw_outstanding", 64'(outstanding), 64'd0);
                if (exp_aw_q.size() == 0) unexpected("aw");
                else begin
                    ea = exp_aw_q.pop_front();
                    check("aw_addr", 64'(AWADDR), 64'(ea[35:4]));
                    check("aw_len", 64'(AWLEN), 64'(ea[3:0]));
                end
                outstanding++;
                aw_cnt++;
            end
            if (WVALID && WREADY) begin
                if (exp_w_q.size() == 0) unexpected("w");
                else begin
                    ew = exp_w_q.pop_front();
                    check("w_data", 64'(WDATA), 64'(ew[31:0]));
                    check("w_last", 64'(WLAST), 64'(ew[32]));
                end
                w_hs_cnt++;
                if (WLAST) f_w_last_hs = 1;
            end
            if (BVALID && BREADY) begin
                f_b_hs = 1;
                b_cnt++;
                b_cyc = cyc;
                outstanding--;
            end
            if (s_valid && s_ready) f_s_hs = 1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            held = 0;
        end
    end

    // Stream source and AXI slave, driven just after the rising edge.
    initial begin
        s_valid = 0; s_data = 0; AWREADY = 1; WREADY = 1;
        BVALID = 0; BRESP = 0; BID = ID;
        forever begin
            @(posedge CLK);
            #1;
            if (!RSTn) begin
                BVALID = 0;
                bpend = 0;
                s_valid = 0;
            end else begin
                WREADY = wtoggle ? !WREADY : 1'b1;
                if (f_s_hs && src_q.size() > 0) void'(src_q.pop_front());
                if (src_q.size() == 0) s_valid = 0;
                else if (!(s_valid && !f_s_hs)) s_valid = !gaps || ($urandom_range(0, 1) == 1);
                if (src_q.size() > 0) s_data = src_q[0];
                if (f_b_hs) BVALID = 0;
                if (f_w_last_hs) bpend = 1;
                if (bpend && !BVALID) begin
                    BVALID = 1;
                    BRESP = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
                    bpend = 0;
                end
            end
        end
    end

    task automatic run_xfer(input logic [31:0] base, input logic [15:0] cnt);
        @(posedge CLK);
        #1;
        base_addr = base;
        word_cnt = cnt;
        start = 1;
        @(posedge CLK);
        #1;
        start = 0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < maxc) begin
            @(posedge CLK);
            k++;
        end
        check(name, 64'(done_cnt > d0), 64'd1);
    endtask

    task automatic load(input logic [31:0] base, input int cnt, input logic [31:0] d0, input logic [31:0] step, input int send);
        int left = cnt;
        logic [31:0] a = base;
        int idx = 0;
        while (left > 0) begin
            int beats = (left > 16) ? 16 : left;
            exp_aw_q.push_back({a, 4'(beats - 1)});
            for (int j = 0; j < beats; j++) begin
                exp_w_q.push_back({(j == beats - 1), d0 + step * idx});
                idx++;
            end
            a = a + 32'(beats * 4);
            left -= beats;
            if (send < cnt) break;
        end
        for (int i = 0; i < ((send > cnt) ? send : cnt); i++) src_q.push_back(d0 + step * i);
    endtask

    task automatic check_clean(input string tag);
        check({tag, "_aw_q_empty"}, 64'(exp_aw_q.size()), 64'd0);
        check({tag, "_w_q_empty"}, 64'(exp_w_q.size()), 64'd0);
    endtask

    initial begin
        int b0, d0, aw0, w0, st, k;
        RSTn = 0; start = 0; base_addr = 0; word_cnt = 0;
        repeat (3) @(posedge CLK);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_awvalid", 64'(AWVALID), 64'd0);
        check("rst_wvalid", 64'(WVALID), 64'd0);
        check("rst_bready", 64'(BREADY), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_awaddr", 64'(AWADDR), 64'd0);
        check("rst_wdata", 64'(WDATA), 64'd0);
        check("rst_awsize", 64'(AWSIZE), 64'd2);
        @(posedge CLK);
        #1;
        RSTn = 1;

        // single 4-word burst
        load(32'h100, 4, 32'hA0, 32'd1, 4);
        b0 = b_cnt;
        run_xfer(32'h100, 16'd4);
        wait_done("t1_done", 200);
        check("t1_b_count", 64'(b_cnt - b0), 64'd1);
        check("t1_done_lat", 64'(done_cyc - b_cyc), 64'd1);
        check("t1_err", 64'(err), 64'd0);
        check_clean("t1");
        @(negedge CLK);
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // 20 words split 16 + 4
        load(32'h100, 20, 32'h1000, 32'd1, 20);
        b0 = b_cnt;
        run_xfer(32'h100, 16'd20);
        wait_done("t2_done", 400);
        check("t2_b_count", 64'(b_cnt - b0), 64'd2);
        check_clean("t2");

        // backpressure, stream gaps and address wrap
        gaps = 1; wtoggle = 1;
        load(32'hFFFF_FFC0, 20, 32'h3000, 32'd7, 20);
        run_xfer(32'hFFFF_FFC3, 16'd20);
        wait_done("t3_done", 1000);
        check_clean("t3");
        gaps = 0; wtoggle = 0;
        repeat (2) @(posedge CLK);

        // SLVERR on first burst aborts the rest
        load(32'h200, 20, 32'h4000, 32'd1, 0);
        for (int i = 16; i < 20; i++) src_q.push_back(32'h4000 + i);
        resp_q.push_back(2'b10);
        aw0 = aw_cnt;
        b0 = b_cnt;
        run_xfer(32'h200, 16'd20);
        wait_done("t4_done", 400);
        check("t4_err", 64'(err), 64'd1);
        check("t4_b_count", 64'(b_cnt - b0), 64'd1);
        repeat (5) @(posedge CLK);
        src_q.delete();
        check("t4_aw_count", 64'(aw_cnt - aw0), 64'd1);
        check("t4_err_sticky", 64'(err), 64'd1);
        check("t4_wvalid", 64'(WVALID), 64'd0);
        check_clean("t4");

        // reset during beat 2 of 4
        load(32'h500, 4, 32'h5000, 32'd1, 4);
        w0 = w_hs_cnt;
        run_xfer(32'h500, 16'd4);
        k = 0;
        while (w_hs_cnt - w0 < 1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check("t5_first_beat", 64'(w_hs_cnt - w0 >= 1), 64'd1);
        @(posedge CLK);
        #2;
        RSTn = 0;
        #1;
        check("t5_awvalid", 64'(AWVALID), 64'd0);
        check("t5_wvalid", 64'(WVALID), 64'd0);
        check("t5_bready", 64'(BREADY), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        exp_aw_q.delete(); exp_w_q.delete(); src_q.delete(); resp_q.delete();
        outstanding = 0;
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1;

        // clean run after reset
        load(32'h600, 5, 32'h6000, 32'd3, 5);
        run_xfer(32'h600, 16'd5);
        wait_done("t6_done", 200);
        check("t6_err", 64'(err), 64'd0);
        check_clean("t6");

        // zero-length transfer
        aw0 = aw_cnt; w0 = w_hs_cnt;
        @(posedge CLK);
        #1;
        base_addr = 32'h700; word_cnt = 16'd0; start = 1;
        st = cyc;
        @(posedge CLK);
        #1;
        start = 0;
        wait_done("t7_done", 10);
        check("t7_latency", 64'((done_cyc - st) <= 2), 64'd1);
        repeat (3) @(posedge CLK);
        check("t7_no_aw", 64'(aw_cnt - aw0), 64'd0);
        check("t7_no_w", 64'(w_hs_cnt - w0), 64'd0);

        // start while busy is ignored
        load(32'h800, 2, 32'h8000, 32'd1, 2);
        d0 = done_cnt; aw0 = aw_cnt;
        run_xfer(32'h800, 16'd2);
        base_addr = 32'h900; word_cnt = 16'd7; start = 1;
        @(posedge CLK);
        #1;
        start = 0;
        wait_done("t8_done", 200);
        repeat (10) @(posedge CLK);
        check("t8_done_count", 64'(done_cnt - d0), 64'd1);
        check("t8_aw_count", 64'(aw_cnt - aw0), 64'd1);
        check_clean("t8");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
